// File: rtl/lane_pipe_array_if.sv
// Per-lane valid/ready streaming bus for lane_pipe_array: input side and output side,
// with lane l's data at bits [l*WIDTH +: WIDTH].
interface lane_pipe_array_if #(
  parameter int LANES = 6,
  parameter int WIDTH = 2
);
  logic [LANES-1:0]       in_valid;
  logic [LANES-1:0]       in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES-1:0]       out_ready;
  logic [LANES*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lane_pipe_array.sv
// LANES independent elastic pipelines of DEPTH stages; each accepted beat is transformed
// by mode on entry and emerges DEPTH cycles later with full-rate, lossless backpressure.
module lane_pipe_lane #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int LO = WIDTH / 2;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t [DEPTH-1:0] stg;
  logic   [DEPTH-1:0] adv;
  logic   [DEPTH-1:0] vld_pipe;
  logic               room;
  logic               accept;
  logic   [WIDTH-1:0] xform;

  // Walk from the output back: a stage moves when everything ahead has room or moves.
  always_comb begin
    room     = out_ready;
    adv      = '0;
    vld_pipe = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      vld_pipe[k] = stg[k].vld;
      adv[k]      = stg[k].vld && room;
      room        = room || !stg[k].vld;
    end
  end

  assign in_ready = room && !flush && !rst;
  assign accept   = in_valid && in_ready;

  // Half-swap is a rotate right by floor(WIDTH/2); degenerates to pass at WIDTH=1.
  always_comb begin
    xform = in_data;
    case (mode)
      2'd1: for (int i = 0; i < WIDTH; i++) xform[i] = in_data[(i + LO) % WIDTH];
      2'd2: xform = ~in_data;
      2'd3: for (int i = 0; i < WIDTH; i++) xform[i] = in_data[WIDTH - 1 - i];
      default: xform = in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) stg[k].vld <= 1'b0;
    end else begin
      if (accept) begin
        stg[0].vld  <= 1'b1;
        stg[0].data <= xform;
      end else if (adv[0]) begin
        stg[0].vld <= 1'b0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k-1])    stg[k]     <= stg[k-1];
        else if (adv[k]) stg[k].vld <= 1'b0;
      end
    end
  end

  assign out_valid = stg[DEPTH-1].vld;
  assign out_data  = stg[DEPTH-1].data;
  assign busy      = |vld_pipe;
endmodule

module lane_pipe_array #(
  parameter int LANES = 6,
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       mode,
  output logic [LANES-1:0] lane_busy,
  lane_pipe_array_if.slave bus
);
  logic [LANES-1:0][WIDTH-1:0] in_d, out_d;
  logic [LANES-1:0]            in_rdy, out_vld;

  assign in_d          = bus.in_data;
  assign bus.out_data  = out_d;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;

  lane_pipe_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane [LANES-1:0] (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .mode      (mode),
    .in_valid  (bus.in_valid),
    .in_ready  (in_rdy),
    .in_data   (in_d),
    .out_valid (out_vld),
    .out_ready (bus.out_ready),
    .out_data  (out_d),
    .busy      (lane_busy)
  );
endmodule
